// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter that shares one single-port 32-bit memory among
// instruction reads, data writes and data reads. Requests that lose are held
// and drained while mem_wait stalls the pipeline.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_wait,
  input  logic                  inst_rden,
  input  logic [31:0]           inst_riaddr,
  output logic [31:0]           inst_roaddr,
  output logic                  inst_rvalid,
  output logic [31:0]           inst_rdata,
  input  logic                  data_rden,
  input  logic [31:0]           data_riaddr,
  output logic [31:0]           data_roaddr,
  output logic                  data_rvalid,
  output logic [31:0]           data_rdata,
  input  logic                  data_wren,
  input  logic [3:0]            data_wstrb,
  input  logic [31:0]           data_waddr,
  input  logic [31:0]           data_wdata,
  output logic                  m_rden,
  output logic                  m_wren,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [3:0]            m_wstrb,
  output logic [31:0]           m_wdata,
  input  logic [31:0]           m_rdata
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]  state_reg, state_next;

  logic        pend_ir_vld_reg, pend_ir_vld_next;
  logic [31:0] pend_ir_addr_reg, pend_ir_addr_next;
  logic        pend_dw_vld_reg, pend_dw_vld_next;
  logic [31:0] pend_dw_addr_reg, pend_dw_addr_next;
  logic [3:0]  pend_dw_strb_reg, pend_dw_strb_next;
  logic [31:0] pend_dw_data_reg, pend_dw_data_next;
  logic        pend_dr_vld_reg, pend_dr_vld_next;
  logic [31:0] pend_dr_addr_reg, pend_dr_addr_next;

  logic        tag_ir_reg, tag_dr_reg;
  logic [31:0] rsp_addr_reg;

  logic        cand_ir, cand_dw, cand_dr;
  logic [31:0] cand_ir_addr, cand_dw_addr, cand_dr_addr, cand_dw_data;
  logic [3:0]  cand_dw_strb;
  logic        gnt_ir, gnt_dw, gnt_dr;
  logic [31:0] sel_addr;
  logic        draining;

  assign draining = (state_reg == ST_DRAIN);

  // In DRAIN the candidates come from the pending registers only; the live
  // inputs are ignored. Reset gates every grant so the memory sees nothing.
  always_comb begin
    cand_ir      = rst & (draining ? pend_ir_vld_reg : inst_rden);
    cand_dw      = rst & (draining ? pend_dw_vld_reg : data_wren);
    cand_dr      = rst & (draining ? pend_dr_vld_reg : data_rden);
    cand_ir_addr = draining ? pend_ir_addr_reg : inst_riaddr;
    cand_dw_addr = draining ? pend_dw_addr_reg : data_waddr;
    cand_dw_strb = draining ? pend_dw_strb_reg : data_wstrb;
    cand_dw_data = draining ? pend_dw_data_reg : data_wdata;
    cand_dr_addr = draining ? pend_dr_addr_reg : data_riaddr;

    gnt_ir = cand_ir;
    gnt_dw = cand_dw & ~cand_ir;
    gnt_dr = cand_dr & ~cand_ir & ~cand_dw;

    sel_addr = '0;
    if (gnt_ir)      sel_addr = cand_ir_addr;
    else if (gnt_dw) sel_addr = cand_dw_addr;
    else if (gnt_dr) sel_addr = cand_dr_addr;
  end

  assign m_rden  = gnt_ir | gnt_dr;
  assign m_wren  = gnt_dw;
  assign m_addr  = ADDR_WIDTH'(sel_addr >> 2);
  assign m_wstrb = gnt_dw ? cand_dw_strb : 4'h0;
  assign m_wdata = gnt_dw ? cand_dw_data : 32'h0;

  always_comb begin
    pend_ir_addr_next = pend_ir_addr_reg;
    pend_dw_addr_next = pend_dw_addr_reg;
    pend_dw_strb_next = pend_dw_strb_reg;
    pend_dw_data_next = pend_dw_data_reg;
    pend_dr_addr_next = pend_dr_addr_reg;
    if (draining) begin
      pend_ir_vld_next = pend_ir_vld_reg & ~gnt_ir;
      pend_dw_vld_next = pend_dw_vld_reg & ~gnt_dw;
      pend_dr_vld_next = pend_dr_vld_reg & ~gnt_dr;
    end else begin
      pend_ir_vld_next = cand_ir & ~gnt_ir;
      pend_dw_vld_next = cand_dw & ~gnt_dw;
      pend_dr_vld_next = cand_dr & ~gnt_dr;
      if (pend_ir_vld_next) pend_ir_addr_next = inst_riaddr;
      if (pend_dw_vld_next) begin
        pend_dw_addr_next = data_waddr;
        pend_dw_strb_next = data_wstrb;
        pend_dw_data_next = data_wdata;
      end
      if (pend_dr_vld_next) pend_dr_addr_next = data_riaddr;
    end
    state_next = (pend_ir_vld_next | pend_dw_vld_next | pend_dr_vld_next) ? ST_DRAIN : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      pend_ir_vld_reg  <= 1'b0;
      pend_ir_addr_reg <= '0;
      pend_dw_vld_reg  <= 1'b0;
      pend_dw_addr_reg <= '0;
      pend_dw_strb_reg <= '0;
      pend_dw_data_reg <= '0;
      pend_dr_vld_reg  <= 1'b0;
      pend_dr_addr_reg <= '0;
      tag_ir_reg       <= 1'b0;
      tag_dr_reg       <= 1'b0;
      rsp_addr_reg     <= '0;
    end else begin
      state_reg        <= state_next;
      pend_ir_vld_reg  <= pend_ir_vld_next;
      pend_ir_addr_reg <= pend_ir_addr_next;
      pend_dw_vld_reg  <= pend_dw_vld_next;
      pend_dw_addr_reg <= pend_dw_addr_next;
      pend_dw_strb_reg <= pend_dw_strb_next;
      pend_dw_data_reg <= pend_dw_data_next;
      pend_dr_vld_reg  <= pend_dr_vld_next;
      pend_dr_addr_reg <= pend_dr_addr_next;
      tag_ir_reg       <= gnt_ir;
      tag_dr_reg       <= gnt_dr;
      rsp_addr_reg     <= (gnt_ir | gnt_dr) ? sel_addr : 32'h0;
    end
  end

  assign mem_wait = pend_ir_vld_reg | pend_dw_vld_reg | pend_dr_vld_reg;

  // Memory data arrives one cycle after the read grant, aligned with the tag.
  assign inst_rvalid = tag_ir_reg;
  assign inst_roaddr = tag_ir_reg ? rsp_addr_reg : 32'h0;
  assign inst_rdata  = tag_ir_reg ? m_rdata : 32'h0;
  assign data_rvalid = tag_dr_reg;
  assign data_roaddr = tag_dr_reg ? rsp_addr_reg : 32'h0;
  assign data_rdata  = tag_dr_reg ? m_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural memory, a response
// scoreboard queue and a negedge monitor that checks every read response.
module tb_mem_port_arbiter;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_wait;
  logic          inst_rden, data_rden, data_wren;
  logic [31:0]   inst_riaddr, data_riaddr, data_waddr, data_wdata;
  logic [3:0]    data_wstrb;
  logic [31:0]   inst_roaddr, inst_rdata, data_roaddr, data_rdata;
  logic          inst_rvalid, data_rvalid;
  logic          m_rden, m_wren;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_wstrb;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = 32'h0;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .mem_wait(mem_wait),
    .inst_rden(inst_rden), .inst_riaddr(inst_riaddr),
    .inst_roaddr(inst_roaddr), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_rden(data_rden), .data_riaddr(data_riaddr),
    .data_roaddr(data_roaddr), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .data_wren(data_wren), .data_wstrb(data_wstrb),
    .data_waddr(data_waddr), .data_wdata(data_wdata),
    .m_rden(m_rden), .m_wren(m_wren), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Word i initially holds 0xA5A5_0000 | i.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_0000 | i;
  end

  always @(posedge clk) begin
    if (m_wren) begin
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    if (m_rden) m_rdata <= mem[m_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic expect_rsp(input bit is_data, input logic [31:0] addr, input logic [31:0] data);
    rsp_t r;
    r.is_data = is_data;
    r.addr    = addr;
    r.data    = data;
    exp_q.push_back(r);
  endtask

  task automatic pop_rsp(input bit is_data, input logic [31:0] addr, input logic [31:0] data);
    rsp_t r;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_rsp: got port=%0d addr=0x%08h data=0x%08h expected none",
               is_data, addr, data);
    end else begin
      r = exp_q.pop_front();
      chk("rsp_port", 32'(is_data), 32'(r.is_data));
      chk("rsp_addr", addr, r.addr);
      chk("rsp_data", data, r.data);
    end
  endtask

  // Monitor: every response is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (inst_rvalid && data_rvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL both_rvalid: got inst=1 data=1 expected one");
    end else if (inst_rvalid) begin
      pop_rsp(1'b0, inst_roaddr, inst_rdata);
      chk("idle_data_port", data_roaddr | data_rdata, 32'h0);
    end else if (data_rvalid) begin
      pop_rsp(1'b1, data_roaddr, data_rdata);
      chk("idle_inst_port", inst_roaddr | inst_rdata, 32'h0);
    end
  end

  task automatic clear_req();
    inst_rden = 1'b0; inst_riaddr = '0;
    data_rden = 1'b0; data_riaddr = '0;
    data_wren = 1'b0; data_waddr = '0; data_wstrb = '0; data_wdata = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    clear_req();
    inst_rden = 1'b1; inst_riaddr = 32'h10;
    repeat (2) next_cycle();
    #1;
    chk("rst_mem_wait", 32'(mem_wait), 32'h0);
    chk("rst_m_rden", 32'(m_rden), 32'h0);
    chk("rst_m_wren", 32'(m_wren), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_rvalids", 32'({inst_rvalid, data_rvalid}), 32'h0);
    clear_req();
    rst = 1'b1;

    // Lone instruction read on the first edge after release
    inst_rden = 1'b1; inst_riaddr = 32'h10;
    #1;
    chk("ir_m_rden", 32'(m_rden), 32'h1);
    chk("ir_m_addr", 32'(m_addr), 32'h4);
    chk("ir_m_wren", 32'(m_wren), 32'h0);
    expect_rsp(1'b0, 32'h10, 32'hA5A5_0004);
    next_cycle(); clear_req(); #1;
    chk("ir_mem_wait", 32'(mem_wait), 32'h0);
    chk("ir_idle_rden", 32'(m_rden), 32'h0);

    // Three-way collision: IR, then DW, then DR returning the written word
    next_cycle();
    inst_rden = 1'b1; inst_riaddr = 32'h0;
    data_wren = 1'b1; data_waddr = 32'h20; data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    data_rden = 1'b1; data_riaddr = 32'h20;
    #1;
    chk("c0_m_rden", 32'(m_rden), 32'h1);
    chk("c0_m_addr", 32'(m_addr), 32'h0);
    chk("c0_mem_wait", 32'(mem_wait), 32'h0);
    expect_rsp(1'b0, 32'h0, 32'hA5A5_0000);
    next_cycle(); clear_req();
    inst_rden = 1'b1; inst_riaddr = 32'h44;
    #1;
    chk("c1_mem_wait", 32'(mem_wait), 32'h1);
    chk("c1_m_wren", 32'(m_wren), 32'h1);
    chk("c1_m_rden", 32'(m_rden), 32'h0);
    chk("c1_m_addr", 32'(m_addr), 32'h8);
    chk("c1_m_wstrb", 32'(m_wstrb), 32'hF);
    chk("c1_m_wdata", m_wdata, 32'hDEAD_BEEF);
    next_cycle(); #1;
    chk("c2_mem_wait", 32'(mem_wait), 32'h1);
    chk("c2_m_rden", 32'(m_rden), 32'h1);
    chk("c2_m_addr", 32'(m_addr), 32'h8);
    chk("c2_m_wdata", m_wdata, 32'h0);
    expect_rsp(1'b1, 32'h20, 32'hDEAD_BEEF);
    next_cycle(); clear_req(); #1;
    chk("c3_mem_wait", 32'(mem_wait), 32'h0);
    chk("c3_m_rden", 32'(m_rden), 32'h0);

    // Partial-strobe write, no response, then read back merged word
    next_cycle();
    data_wren = 1'b1; data_waddr = 32'h30; data_wstrb = 4'h3; data_wdata = 32'h1122_3344;
    #1;
    chk("pw_m_wren", 32'(m_wren), 32'h1);
    chk("pw_m_wstrb", 32'(m_wstrb), 32'h3);
    chk("pw_m_wdata", m_wdata, 32'h1122_3344);
    chk("pw_m_addr", 32'(m_addr), 32'hC);
    next_cycle(); clear_req(); #1;
    chk("pw_done_wren", 32'(m_wren), 32'h0);
    chk("pw_no_rvalid", 32'({inst_rvalid, data_rvalid}), 32'h0);
    next_cycle();
    data_rden = 1'b1; data_riaddr = 32'h30;
    #1;
    chk("pr_m_rden", 32'(m_rden), 32'h1);
    expect_rsp(1'b1, 32'h30, 32'hA5A5_3344);
    next_cycle(); clear_req();

    // Back-to-back reads, low address bits ignored, then IR+DR collision
    next_cycle();
    inst_rden = 1'b1; inst_riaddr = 32'h100;
    #1;
    expect_rsp(1'b0, 32'h100, 32'hA5A5_0040);
    next_cycle(); clear_req();
    data_rden = 1'b1; data_riaddr = 32'h107;
    #1;
    chk("bb_m_addr", 32'(m_addr), 32'h41);
    expect_rsp(1'b1, 32'h107, 32'hA5A5_0041);
    next_cycle(); clear_req();
    inst_rden = 1'b1; inst_riaddr = 32'h8;
    data_rden = 1'b1; data_riaddr = 32'hC;
    #1;
    chk("col_m_addr", 32'(m_addr), 32'h2);
    expect_rsp(1'b0, 32'h8, 32'hA5A5_0002);
    next_cycle(); clear_req(); #1;
    chk("col_mem_wait", 32'(mem_wait), 32'h1);
    chk("col_m_rden", 32'(m_rden), 32'h1);
    chk("col_dr_addr", 32'(m_addr), 32'h3);
    expect_rsp(1'b1, 32'hC, 32'hA5A5_0003);
    next_cycle(); #1;
    chk("col_end_wait", 32'(mem_wait), 32'h0);

    // Reset in the middle of a drain discards the pending write and read
    next_cycle();
    inst_rden = 1'b1; inst_riaddr = 32'h0;
    data_wren = 1'b1; data_waddr = 32'h40; data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D;
    data_rden = 1'b1; data_riaddr = 32'h40;
    #1;
    expect_rsp(1'b0, 32'h0, 32'hA5A5_0000);
    next_cycle(); clear_req(); #1;
    chk("rd_mem_wait", 32'(mem_wait), 32'h1);
    chk("rd_m_wren", 32'(m_wren), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rd_rst_wait", 32'(mem_wait), 32'h0);
    chk("rd_rst_wren", 32'(m_wren), 32'h0);
    chk("rd_rst_wdata", m_wdata, 32'h0);
    chk("rd_rst_inst_rvalid", 32'(inst_rvalid), 32'h0);
    chk("rd_rst_inst_rdata", inst_rdata, 32'h0);
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk("post_rst_data_rvalid", 32'(data_rvalid), 32'h0);
      chk("post_rst_wait", 32'(mem_wait), 32'h0);
    end
    data_rden = 1'b1; data_riaddr = 32'h40;
    #1;
    expect_rsp(1'b1, 32'h40, 32'hA5A5_0010);
    next_cycle(); clear_req();
    repeat (2) next_cycle();
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
